mmio_out_fifo: RTL
==================

// Module: mmio_out_fifo
// PURPOSE
//  - Downstream consumer of the chipset CPU/memory bus. Snoops the bus and captures CPU stores to one
//    memory-mapped output address into a small FIFO.
//  - Presents captured words to the board-level output (OUT) through a valid/ready stream.
//  - Lets the CPU emit results without stalling on a slow sink. Overruns are flagged, not hidden.
// PARAMETERS
//  WIDTH     `REGSIZE   data/address width; equals DEFAULT_TYPE
//  OUT_ADDR  '1         bus address decoded as the output port (all-ones of WIDTH)
//  DEPTH     4          FIFO entries; power of two, >=2
// PORTS
//  CLOCK         in   1            system clock, rising edge
//  RESET_N       in   1            asynchronous active-low reset
//  exec_en       in   1            1 only while chipset is in CHIPSET_EXEC_CPU (ROM load writes ignored)
//  bus_addr      in   WIDTH        CPU address bus (cpu_addr_bus)
//  bus_wdata     in   WIDTH        CPU write data (cpu_write_bus)
//  bus_ctrl      in   MEMORY_FLAG  CPU control (cpu_ctrl_bus); store when == MEMORY_WRITE
//  out_data      out  WIDTH        head-of-FIFO word
//  out_valid     out  1            out_data valid
//  out_ready     in   1            sink accepts out_data this cycle
//  fifo_count    out  log2(DEPTH)+1  occupied entries, 0..DEPTH
//  full          out  1            fifo_count == DEPTH
//  overflow      out  1            sticky: a store was dropped
//  drop_count    out  8            dropped stores, saturates at 8'hFF
// BEHAVIOUR
//  - Reset (RESET_N low, async assert, sync deassert by top level):
//    - FIFO empty; out_valid=0, out_data=0, fifo_count=0, full=0, overflow=0, drop_count=0.
//  - push = exec_en & (bus_ctrl==MEMORY_WRITE) & (bus_addr==OUT_ADDR); sampled each rising edge.
//  - pop  = out_valid & out_ready.
//  - Each cycle of a held store counts as one push. CPU holds MEMORY_WRITE for exactly one cycle per store.
//  - Storage: circular buffer; wr_ptr/rd_ptr are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
//    - Count is kept in a separate register; no pointer-MSB trick.
//  - Latency: a push at edge N makes out_valid=1 and out_data=word after edge N.
//    - There is no bypass; out_data is driven from the storage register indexed by rd_ptr.
//  - out_data holds its value while out_valid & !out_ready (AXI-style stability).
//    - out_valid never drops without a pop.
//  - When empty, out_data shows the last popped word (0 after reset); the sink must ignore it.
//  - Count update: push & !pop -> +1; pop & !push -> -1; both -> unchanged, both pointers advance.
//  - Full and push:
//    - With pop in the same cycle: the push is accepted (slot freed by pop).
//    - Without pop: the word is dropped, overflow<=1 (sticky until reset), drop_count<=sat(drop_count+1).
//    - FIFO contents are unchanged.
//  - Empty and push: the pop term is 0 by definition; the word is written and count becomes 1.
//  - Stores to other addresses and any bus activity while exec_en=0 have no effect.
//  - Reset mid-operation: all contents are discarded, pointers return to 0, all outputs return to reset values.
//    - No partial word is emitted.
//  - State machine is implicit in count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
//    - EMPTY -> PARTIAL on push.
//    - PARTIAL -> FULL on push without pop at count DEPTH-1.
//    - FULL -> PARTIAL on pop without push.
//    - PARTIAL -> EMPTY on pop without push at count 1.
//  - All outputs are registered or decoded from registers only; no combinational path from bus inputs to outputs.
// TESTING
//  - Reset, then exec_en=1, store 8'h2A to OUT_ADDR, out_ready=0.
//    -> next cycle out_valid=1, out_data=8'h2A, fifo_count=1; value held for 10 cycles.
//  - exec_en=0, store to OUT_ADDR (ROM-load phase)
//    -> fifo_count stays 0, out_valid stays 0.
//  - out_ready=0, store 1,2,3,4,5 on consecutive cycles
//    -> full=1 after 4th; 5th dropped, overflow=1, drop_count=1.
//    -> then out_ready=1 drains 1,2,3,4 in order; out_valid=0 after.
//  - Full FIFO, simultaneous store 9 and out_ready=1
//    -> head popped, 9 accepted at tail, fifo_count stays 4, overflow unchanged.
//  - Wrap: push/pop 3*DEPTH+1 words at 1/cycle with out_ready=1
//    -> output sequence identical to input, one-cycle latency, fifo_count never above 1.
//  - Assert RESET_N=0 mid-cycle with 3 entries queued
//    -> out_valid=0, fifo_count=0 immediately (async).
//    -> after release, next store appears alone.
//  - 260 dropped stores while full
//    -> drop_count saturates at 8'hFF.

Source files
------------

// File: rtl/mmio_out_fifo_if.sv
// -----------------------------------------------------------------------------
// mmio_out_fifo_if
// Groups the snooped CPU bus signals, the OUT valid/ready stream and the FIFO
// status signals of mmio_out_fifo into one bundle.
//
// Signals
//   exec_en     chipset is executing CPU code (ROM-load writes must be ignored)
//   bus_addr    CPU address bus
//   bus_wdata   CPU write data
//   bus_ctrl    CPU control; a store is bus_ctrl == MEMORY_WRITE
//   out_data    head-of-FIFO word
//   out_valid   out_data holds a queued word
//   out_ready   sink accepts out_data this cycle
//   fifo_count  occupied entries, 0..DEPTH
//   full        fifo_count == DEPTH
//   overflow    sticky: a store was dropped
//   drop_count  dropped stores, saturating at 8'hFF
//
// Handshake: a word moves on every rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data is held stable and
// out_valid stays high; out_valid only falls after a pop. out_ready may be
// driven freely and does not depend on out_valid.
//
// Modports
//   master  side that drives the bus and sinks the stream (chipset/board)
//   slave   the FIFO itself
// -----------------------------------------------------------------------------
interface mmio_out_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              exec_en;
    logic [WIDTH-1:0]  bus_addr;
    logic [WIDTH-1:0]  bus_wdata;
    logic [CTRL_W-1:0] bus_ctrl;

    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    logic [CW-1:0]     fifo_count;
    logic              full;
    logic              overflow;
    logic [7:0]        drop_count;

    modport master (
        output exec_en, bus_addr, bus_wdata, bus_ctrl, out_ready,
        input  out_data, out_valid, fifo_count, full, overflow, drop_count
    );

    modport slave (
        input  exec_en, bus_addr, bus_wdata, bus_ctrl, out_ready,
        output out_data, out_valid, fifo_count, full, overflow, drop_count
    );
endinterface

// File: rtl/mmio_out_fifo.sv
// -----------------------------------------------------------------------------
// mmio_out_fifo
// Snoops the CPU/memory bus and captures every CPU store to OUT_ADDR into a
// small circular FIFO, then presents the words to the board-level OUT sink
// over a valid/ready stream. Stores arriving while the FIFO is full (and no
// pop frees a slot in the same cycle) are dropped and flagged.
//
// Ports
//   CLOCK        system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   bus          mmio_out_fifo_if.slave: bus snoop inputs, OUT stream, status
//   o_dbg_state  occupancy state: 0 EMPTY, 1 PARTIAL, 2 FULL
//
// All outputs come from registers (or decode of registers only); there is
// no combinational path from the bus inputs to any output.
// -----------------------------------------------------------------------------
module mmio_out_fifo #(
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  OUT_ADDR     = '1,
    parameter int                DEPTH        = 4,
    parameter int                CTRL_W       = 2,
    parameter logic [CTRL_W-1:0] MEMORY_WRITE = CTRL_W'(2)
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    mmio_out_fifo_if.slave        bus,
    output logic [1:0]            o_dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    logic             w_store;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PW-1:0]    w_out_ptr;

    // A store held for several cycles is deliberately seen as several pushes.
    assign w_store = bus.exec_en && (bus.bus_ctrl == MEMORY_WRITE) && (bus.bus_addr == OUT_ADDR);

    assign w_valid = (r_state != ST_EMPTY);
    assign w_full  = (r_state == ST_FULL);
    assign w_pop   = w_valid && bus.out_ready;

    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push  = w_store && (!w_full || w_pop);
    assign w_drop  = w_store && w_full && !w_pop;

    // While empty, show the slot just behind rd_ptr: that is the last word
    // popped (or the reset value 0), so out_data does not jump to stale data.
    assign w_out_ptr = w_valid ? r_rd_ptr : (r_rd_ptr - PW'(1));

    // Occupancy FSM; its state always mirrors r_count.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_next_state = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
                    w_next_state = ST_FULL;
                end else if (w_pop && !w_push && (r_count == CW'(1))) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop && !w_push) begin
                    w_next_state = ST_PARTIAL;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    // Storage; cleared on reset so an empty FIFO after reset shows 0.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.bus_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign bus.out_data   = r_mem[w_out_ptr];
    assign bus.out_valid  = w_valid;
    assign bus.fifo_count = r_count;
    assign bus.full       = w_full;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;
    assign o_dbg_state    = r_state;
endmodule
